// File: rtl/multi_tick_divider.sv
// Multi-channel programmable clock-enable generator with shadowed divisors and phase-aligning clear.
// Optional 50% square-wave outputs are built when TICKDIV_SQUARE_EN is defined; otherwise sq is tied to 0.
module multi_tick_divider #(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DEFAULT_DIV = 50_000_000,
  parameter int unsigned CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CHW-1:0]    wr_ch,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0]  count [NUM_CH];
  logic [WIDTH-1:0]  act   [NUM_CH];
  logic [WIDTH-1:0]  shd   [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] wrap;

  // Out-of-range wr_ch matches no channel, so such writes fall away naturally.
  always_comb begin
    wr_hit = '0;
    wrap   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_en && (wr_ch == CHW'(i));
      wrap[i]   = en[i] && !clear && (count[i] == act[i]);
    end
  end

  // Counters, divisor shadow/active pair and tick flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count[i] <= '0;
        act[i]   <= DIV_RST;
        shd[i]   <= DIV_RST;
      end
      tick <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) begin
          shd[i] <= wr_data;
        end
        if (clear) begin
          // Clear with a same-cycle write adopts the new divisor at once.
          count[i] <= '0;
          tick[i]  <= 1'b0;
          act[i]   <= wr_hit[i] ? wr_data : shd[i];
        end else if (wrap[i]) begin
          count[i] <= '0;
          tick[i]  <= 1'b1;
          act[i]   <= shd[i];
        end else if (en[i]) begin
          count[i] <= count[i] + WIDTH'(1);
          tick[i]  <= 1'b0;
        end else begin
          tick[i]  <= 1'b0;
        end
      end
    end
  end

`ifdef TICKDIV_SQUARE_EN
  // Square wave toggles on every wrap, giving a period of 2*(act+1).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sq <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (clear) begin
          sq[i] <= 1'b0;
        end else if (wrap[i]) begin
          sq[i] <= ~sq[i];
        end
      end
    end
  end
`else
  assign sq = '0;
`endif

endmodule
